// File: rtl/x_operand_buffer.sv
// X-operand buffer: streams bus words into BANKS row banks, rotates them element-wise on x_shift,
// and presents a shift_count-selected window. Optional build macro: XBUF_SEL_ROTATE_EN.
module x_operand_buffer #(
  parameter int ELEM_W          = 8,
  parameter int WORD_W          = 32,
  parameter int BANKS           = 3,
  parameter int BANK_ELEMS      = 9,
  parameter int WIN_ELEMS       = 7,
  parameter int SHIFTS_PER_BANK = 3,
  parameter int SC_W            = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WORD_W-1:0]                     in_data,
  input  logic                                  x_shift,
  input  logic [SC_W-1:0]                       shift_count,
  output logic [WIN_ELEMS*ELEM_W-1:0]           x_win,
  output logic                                  x_valid,
  output logic                                  load_done,
  output logic [$clog2(BANK_ELEMS)-1:0]         rot_cnt
);

  localparam int EPW   = WORD_W / ELEM_W;
  localparam int WPB   = (BANK_ELEMS + EPW - 1) / EPW;
  localparam int WIN_W = WIN_ELEMS * ELEM_W;
  localparam int RC_W  = $clog2(BANK_ELEMS);
  localparam int WC_W  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int BC_W  = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t state_reg, state_next;

  // elem_reg[b][p]: position p=0 is the MSB element of the bank
  logic [ELEM_W-1:0] elem_reg [BANKS][BANK_ELEMS];
  logic [WC_W-1:0]   word_cnt_reg;
  logic [BC_W-1:0]   bank_cnt_reg;
  logic [RC_W-1:0]   rot_cnt_reg;

  logic            accept;
  logic            last_word;
  logic            shift_en;
  logic [SC_W-1:0] sel;

  assign in_ready  = (state_reg == LOAD);
  assign x_valid   = (state_reg == FULL);
  assign load_done = x_valid;
  assign rot_cnt   = rot_cnt_reg;

  // load_start takes priority: a coincident word or rotation is dropped
  assign accept    = in_valid & in_ready & ~load_start;
  assign last_word = accept && (word_cnt_reg == WC_W'(WPB - 1)) && (bank_cnt_reg == BC_W'(BANKS - 1));
  assign shift_en  = (state_reg == FULL) & x_shift & ~load_start;
  assign sel       = shift_count / SC_W'(SHIFTS_PER_BANK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (load_start) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD:    if (last_word) state_next = FULL;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_reg <= '0;
      bank_cnt_reg <= '0;
      rot_cnt_reg  <= '0;
      for (int b = 0; b < BANKS; b++)
        for (int p = 0; p < BANK_ELEMS; p++)
          elem_reg[b][p] <= '0;
    end else if (load_start) begin
      word_cnt_reg <= '0;
      bank_cnt_reg <= '0;
      rot_cnt_reg  <= '0;
      for (int b = 0; b < BANKS; b++)
        for (int p = 0; p < BANK_ELEMS; p++)
          elem_reg[b][p] <= '0;
    end else begin
      if (accept) begin
        // Word k fills positions k*EPW .. k*EPW+EPW-1; positions past the bank end never match
        for (int b = 0; b < BANKS; b++)
          for (int p = 0; p < BANK_ELEMS; p++)
            if (bank_cnt_reg == BC_W'(b) && word_cnt_reg == WC_W'(p / EPW))
              elem_reg[b][p] <= in_data[(p % EPW) * ELEM_W +: ELEM_W];
        if (word_cnt_reg == WC_W'(WPB - 1)) begin
          word_cnt_reg <= '0;
          bank_cnt_reg <= (bank_cnt_reg == BC_W'(BANKS - 1)) ? '0 : bank_cnt_reg + 1'b1;
        end else begin
          word_cnt_reg <= word_cnt_reg + 1'b1;
        end
      end
      if (shift_en) begin
        rot_cnt_reg <= (rot_cnt_reg == RC_W'(BANK_ELEMS - 1)) ? '0 : rot_cnt_reg + 1'b1;
        for (int b = 0; b < BANKS; b++) begin
`ifdef XBUF_SEL_ROTATE_EN
          if (sel == SC_W'(b)) begin
`else
          begin
`endif
            for (int p = 0; p < BANK_ELEMS; p++)
              elem_reg[b][p] <= elem_reg[b][(p + 1) % BANK_ELEMS];
          end
        end
      end
    end
  end

  // Window is purely combinational so shift_count changes show up immediately
  always_comb begin
    x_win = '0;
    for (int b = 0; b < BANKS; b++)
      if (sel == SC_W'(b))
        for (int w = 0; w < WIN_ELEMS; w++)
          x_win[WIN_W - 1 - w * ELEM_W -: ELEM_W] = elem_reg[b][w];
  end

endmodule
